qm_truth_table_checker: RTL and testbench
=========================================

Name: qm_truth_table_checker

Overview:
- Exhaustive stimulus-and-check stage wrapped around the generated minimized-logic netlist (5 inputs {s,a,b,c,d}, 1 output o).
- Drives every input combination into the netlist in turn, waits a programmable settle time for gate delays, samples o, and compares it against an expected truth-table mask.
- Reports pass/fail, the number of mismatches and the first failing index.
- Feeds the netlist's inputs and consumes its output; used to sign off each minimization result.

Parameters:
- N_IN, 5, number of netlist inputs; table depth is 2**N_IN.
- SETTLE_CYCLES, 4, clock cycles each vector is held before o is sampled; legal range >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a full sweep; honoured only in IDLE.
- exp_table  input  2**N_IN  expected o per index; captured on the accepted start.
- dut_in  output  N_IN  vector driven to netlist: [4]=s, [3]=a, [2]=b, [1]=c, [0]=d; index = dut_in.
- dut_out  input  1  netlist output o.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse when the sweep completes.
- pass  output  1  1 when err_count==0 at completion; held until the next accepted start.
- err_count  output  N_IN+1  number of mismatching indices in the last sweep.
- first_err_valid  output  1  at least one mismatch recorded.
- first_err_idx  output  N_IN  lowest mismatching index; valid only with first_err_valid.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_idx=0, captured table cleared.
- Reset mid-sweep aborts immediately: no done pulse, and all outputs take their reset values.
- States: IDLE, SETTLE, DONE.
- IDLE, start=1 at cycle T:
  - capture exp_table.
  - idx=0, dut_in=0.
  - cnt=SETTLE_CYCLES-1.
  - clear err_count, pass, first_err_valid and first_err_idx.
  - go to SETTLE; busy=1 from T+1.
- SETTLE, cnt!=0: cnt decrements; dut_in is held stable.
- SETTLE, cnt==0 (compare cycle):
  - compare dut_out against captured_table[idx].
  - on mismatch: err_count+1.
  - on mismatch with first_err_valid==0: first_err_idx=idx and first_err_valid=1.
  - if idx==2**N_IN-1, go to DONE.
  - otherwise idx+1, dut_in=idx+1 on the same edge, cnt reloads to SETTLE_CYCLES-1.
- Timing: index k is compared at cycle T+SETTLE_CYCLES*(k+1). The final compare is at T+SETTLE_CYCLES*2**N_IN.
- DONE (one cycle):
  - done=1, busy=0.
  - pass = (err_count==0), including the final compare's result.
  - next state IDLE.
  - For defaults, done is at T+129.
- Results stay stable in IDLE until the next accepted start.
- start while busy or in DONE is ignored; there is no queuing.
- start in the same cycle as rst is ignored because reset wins.
- err_count width N_IN+1 holds the maximum 2**N_IN, so no saturation is needed.
- idx wrap-around never occurs; the sweep ends at the last index.
- SETTLE_CYCLES=1: every cycle in SETTLE is a compare cycle and dut_in changes every cycle.
- dut_out is sampled directly on the compare edge. Choosing SETTLE_CYCLES to cover the netlist's worst-case path is the integrator's responsibility.
- exp_table changes after capture have no effect on a running sweep.

Decomposition:
- Package qm_chk_pkg:
  - state enum (IDLE, SETTLE, DONE).
  - default constants QM_N_IN=5 and QM_SETTLE_DEFAULT=4.
  - input bit-position constants IDX_S=4, IDX_A=3, IDX_B=2, IDX_C=1, IDX_D=0.
- One sub-module, qm_settle_timer:
  - loadable down-counter of width $clog2(SETTLE_CYCLES+1).
  - inputs load and enable; output zero flag.
  - the FSM, index counter and scoreboard stay in the top module.

Test Plan:
- Stub DUT o=dut_in[0]; exp_table=32'hAAAA_AAAA; start at T → done only at T+129; pass=1, err_count=0, first_err_valid=0.
- Same stub; exp_table=32'hAAAA_AAAB → pass=0, err_count=1, first_err_idx=0, first_err_valid=1.
- Stub o stuck at 0; exp_table=32'hFFFF_FFFF → err_count=32, first_err_idx=0, pass=0.
- Stub o=dut_in[0]; exp_table=32'hAAA8_AAAA (bit 17 flipped) → err_count=1, first_err_idx=17. Also check dut_in steps 0..31, each value held exactly 4 cycles.
- rst asserted at T+50 of a sweep, with extra start pulses at T+10 and T+60 → the T+10 start is ignored; after rst, all outputs are at reset values and no done pulse occurs; the T+60 start begins a fresh sweep whose done arrives at T+189.
- SETTLE_CYCLES=1 build with the same stub and exp 32'hAAAA_AAAA → done at T+33, pass=1, dut_in changes every cycle.

Source files
------------

// File: rtl/qm_chk_pkg.sv
// Shared types and constants for the minimized-logic truth-table checker.
// Bit positions give the netlist input order {s,a,b,c,d} within dut_in.
package qm_chk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StDone
    } state_e;

    localparam int unsigned QM_N_IN           = 5;
    localparam int unsigned QM_SETTLE_DEFAULT = 4;

    localparam int unsigned IDX_S = 4;
    localparam int unsigned IDX_A = 3;
    localparam int unsigned IDX_B = 2;
    localparam int unsigned IDX_C = 1;
    localparam int unsigned IDX_D = 0;

endpackage

// File: rtl/qm_settle_timer.sv
// Loadable down-counter that paces each vector: zero marks the compare cycle.
// Reload value is SETTLE_CYCLES-1, so a vector is held SETTLE_CYCLES cycles.
module qm_settle_timer
    import qm_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = QM_SETTLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic zero
);

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CntW-1:0] Reload = CntW'(SETTLE_CYCLES - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= Reload;
        end else if (enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/qm_truth_table_checker.sv
// Exhaustive sweep of every input combination into the minimized netlist, comparing
// its output against a captured truth-table mask and recording the mismatch summary.
module qm_truth_table_checker
    import qm_chk_pkg::*;
#(
    parameter int unsigned N_IN          = QM_N_IN,
    parameter int unsigned SETTLE_CYCLES = QM_SETTLE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2**N_IN-1:0] exp_table,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              first_err_valid,
    output logic [N_IN-1:0]   first_err_idx
);

    localparam int unsigned Depth = 2**N_IN;

    state_e             r_state;
    state_e             w_state_d;
    logic [Depth-1:0]   r_table;
    logic [N_IN-1:0]    r_idx;
    logic [N_IN:0]      r_err;
    logic               r_fev;
    logic [N_IN-1:0]    r_fei;
    logic               r_pass;

    logic               w_accept;
    logic               w_load;
    logic               w_zero;
    logic               w_cmp;
    logic               w_last;
    logic               w_mismatch;
    logic [N_IN:0]      w_err_next;

    qm_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .enable (r_state == StSettle),
        .zero   (w_zero)
    );

    assign w_last     = (r_idx == {N_IN{1'b1}});
    assign w_cmp      = (r_state == StSettle) && w_zero;
    assign w_mismatch = w_cmp && (dut_out != r_table[r_idx]);
    assign w_err_next = r_err + {{N_IN{1'b0}}, w_mismatch};

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_load    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_accept  = 1'b1;
                    w_load    = 1'b1;
                    w_state_d = StSettle;
                end
            end
            StSettle: begin
                if (w_zero) begin
                    if (w_last) begin
                        w_state_d = StDone;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_table <= '0;
            r_idx   <= '0;
            r_err   <= '0;
            r_fev   <= 1'b0;
            r_fei   <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_table <= exp_table;
                r_idx   <= '0;
                r_err   <= '0;
                r_fev   <= 1'b0;
                r_fei   <= '0;
                r_pass  <= 1'b0;
            end
            if (w_cmp) begin
                r_err <= w_err_next;
                if (w_mismatch && !r_fev) begin
                    r_fev <= 1'b1;
                    r_fei <= r_idx;
                end
                // Pass is settled on the final compare so it is already valid with done.
                if (w_last) begin
                    r_pass <= (w_err_next == '0);
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign dut_in          = r_idx;
    assign busy            = (r_state == StSettle);
    assign done            = (r_state == StDone);
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_err_valid = r_fev;
    assign first_err_idx   = r_fei;

endmodule

// File: tb/tb_qm_truth_table_checker.sv
// Directed bench: a vector table of stub behaviours and masks, plus hand-written
// sequences for reset mid-sweep, ignored starts and a single-cycle settle build.
module tb_qm_truth_table_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-parameter instance with a configurable stub netlist.
    logic        start0;
    logic [31:0] exp0;
    logic [4:0]  din0;
    logic        dout0;
    logic        busy0, done0, pass0, fev0;
    logic [5:0]  err0;
    logic [4:0]  fei0;
    logic [1:0]  mode0;

    assign dout0 = (mode0 == 2'd0) ? din0[0] : (mode0 == 2'd1) ? 1'b0 : 1'b1;

    qm_truth_table_checker u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .start           (start0),
        .exp_table       (exp0),
        .dut_in          (din0),
        .dut_out         (dout0),
        .busy            (busy0),
        .done            (done0),
        .pass            (pass0),
        .err_count       (err0),
        .first_err_valid (fev0),
        .first_err_idx   (fei0)
    );

    // Single-cycle settle instance, stub o = d.
    logic        start1;
    logic [31:0] exp1;
    logic [4:0]  din1;
    logic        busy1, done1, pass1, fev1;
    logic [5:0]  err1;
    logic [4:0]  fei1;

    qm_truth_table_checker #(
        .N_IN          (5),
        .SETTLE_CYCLES (1)
    ) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .start           (start1),
        .exp_table       (exp1),
        .dut_in          (din1),
        .dut_out         (din1[0]),
        .busy            (busy1),
        .done            (done1),
        .pass            (pass1),
        .err_count       (err1),
        .first_err_valid (fev1),
        .first_err_idx   (fei1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] tbl;
        logic        pass;
        int          err;
        logic        fev;
        int          fei;
    } vec_t;

    vec_t vecs[8];

    // Launch a sweep on DUT0 and watch until done; lat counts cycles after acceptance.
    task automatic run0(input logic [1:0] mode, input logic [31:0] tbl,
                        output int lat, output int step_bad);
        @(negedge clk);
        mode0  = mode;
        exp0   = tbl;
        start0 = 1'b1;
        @(negedge clk);
        start0   = 1'b0;
        exp0     = ~tbl;
        lat      = 1;
        step_bad = 0;
        while (lat <= 300 && done0 !== 1'b1) begin
            if (lat <= 128 && din0 !== 5'((lat - 1) / 4)) step_bad++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int step_bad;
        int done_at;
        int early_done;

        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        exp0   = 32'hFFFF_FFFF;
        exp1   = 32'hFFFF_FFFF;
        mode0  = 2'd0;

        vecs[0] = '{2'd0, 32'hAAAA_AAAA, 1'b1, 0,  1'b0, 0};
        vecs[1] = '{2'd0, 32'hAAAA_AAAB, 1'b0, 1,  1'b1, 0};
        vecs[2] = '{2'd1, 32'hFFFF_FFFF, 1'b0, 32, 1'b1, 0};
        vecs[3] = '{2'd0, 32'hAAA8_AAAA, 1'b0, 1,  1'b1, 17};
        vecs[4] = '{2'd1, 32'h0000_0000, 1'b1, 0,  1'b0, 0};
        vecs[5] = '{2'd0, 32'h5555_5555, 1'b0, 32, 1'b1, 0};
        vecs[6] = '{2'd0, 32'h2AAA_AAAA, 1'b0, 1,  1'b1, 31};
        vecs[7] = '{2'd2, 32'h8000_0000, 1'b0, 31, 1'b1, 0};

        repeat (3) @(negedge clk);
        check("rst_dut_in", din0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_fev", fev0, 0);
        check("rst_fei", fei0, 0);
        check("rst_busy1", busy1, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run0(vecs[i].mode, vecs[i].tbl, lat, step_bad);
            check($sformatf("v%0d_done_lat", i), lat, 129);
            check($sformatf("v%0d_dut_in_steps", i), step_bad, 0);
            check($sformatf("v%0d_pass", i), pass0, vecs[i].pass);
            check($sformatf("v%0d_err", i), err0, vecs[i].err);
            check($sformatf("v%0d_fev", i), fev0, vecs[i].fev);
            check($sformatf("v%0d_fei", i), fei0, vecs[i].fei);
            check($sformatf("v%0d_busy_in_done", i), busy0, 0);
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), done0, 0);
            check($sformatf("v%0d_pass_held", i), pass0, vecs[i].pass);
        end

        // Start presented during the DONE cycle must be dropped.
        run0(2'd0, 32'hAAAA_AAAA, lat, step_bad);
        check("done_seq_lat", lat, 129);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("start_in_done_ignored", busy0, 0);
        @(negedge clk);
        check("start_in_done_still_idle", busy0, 0);

        // Reset mid-sweep with extra start pulses at T+10 and T+60.
        @(negedge clk);
        mode0  = 2'd1;
        exp0   = 32'hFFFF_FFFF;
        start0 = 1'b1;
        @(negedge clk);
        start0     = 1'b0;
        lat        = 1;
        done_at    = 0;
        early_done = 0;
        while (lat < 300 && done_at == 0) begin
            if (lat == 10) start0 = 1'b1;
            if (lat == 11) start0 = 1'b0;
            if (lat == 12) check("start_while_busy_ignored", din0, 2);
            if (lat == 50) begin
                check("pre_rst_err", err0, 12);
                rst = 1'b1;
            end
            if (lat == 51) begin
                rst = 1'b0;
                check("mid_rst_dut_in", din0, 0);
                check("mid_rst_busy", busy0, 0);
                check("mid_rst_done", done0, 0);
                check("mid_rst_pass", pass0, 0);
                check("mid_rst_err", err0, 0);
                check("mid_rst_fev", fev0, 0);
                check("mid_rst_fei", fei0, 0);
            end
            if (lat == 60) start0 = 1'b1;
            if (lat == 61) start0 = 1'b0;
            if (done0 === 1'b1) begin
                if (lat < 189) early_done++;
                else done_at = lat;
            end
            if (done_at == 0) begin
                @(negedge clk);
                lat++;
            end
        end
        check("no_done_after_abort", early_done, 0);
        check("fresh_sweep_done_lat", done_at, 189);
        check("fresh_sweep_err", err0, 32);
        check("fresh_sweep_pass", pass0, 0);

        // Start in the same cycle as reset: reset wins.
        @(negedge clk);
        rst    = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        start0 = 1'b0;
        @(negedge clk);
        check("start_with_rst_ignored", busy0, 0);

        // Single-cycle settle build.
        @(negedge clk);
        exp1   = 32'hAAAA_AAAA;
        start1 = 1'b1;
        @(negedge clk);
        start1   = 1'b0;
        exp1     = 32'h0;
        lat      = 1;
        step_bad = 0;
        while (lat <= 100 && done1 !== 1'b1) begin
            if (lat <= 32 && din1 !== 5'(lat - 1)) step_bad++;
            @(negedge clk);
            lat++;
        end
        check("s1_done_lat", lat, 33);
        check("s1_dut_in_every_cycle", step_bad, 0);
        check("s1_pass", pass1, 1);
        check("s1_err", err1, 0);
        check("s1_fev", fev1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
